// File: rtl/demultiplexor1_4_stream.sv
// Registered 1-to-4 stream demultiplexer.
// One input word per cycle is steered by i_select into one of four
// single-entry slots; each slot drains through its own valid/ready pair.
module demultiplexor1_4_stream #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_valid,
    input  logic [1:0]       i_select,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_q0,
    output logic [WIDTH-1:0] o_q1,
    output logic [WIDTH-1:0] o_q2,
    output logic [WIDTH-1:0] o_q3,
    output logic [3:0]       o_valid,
    input  logic [3:0]       i_ready,
    output logic [15:0]      o_accepted
);

    logic [WIDTH-1:0] slot_q [4];
    logic [3:0]       drain;
    logic [3:0]       fill;
    logic [3:0]       valid_next;
    logic             fire;

    // Input handshake: the chosen slot can take a word if it is empty or
    // being drained this cycle; i_valid is deliberately not involved.
    always_comb begin
        o_ready    = !i_clear && (!o_valid[i_select] || i_ready[i_select]);
        fire       = i_valid && o_ready;
        drain      = o_valid & i_ready;
        fill       = fire ? (4'b0001 << i_select) : 4'b0000;
        valid_next = (o_valid & ~drain) | fill;
    end

    // Full flags and transfer counter; clear flushes flags only.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid    <= 4'b0000;
            o_accepted <= 16'h0000;
        end else if (i_clear) begin
            o_valid    <= 4'b0000;
        end else begin
            o_valid <= valid_next;
            if (fire) begin
                o_accepted <= o_accepted + 16'h0001;
            end
        end
    end

    // Slot data registers; a drained slot keeps its last word.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int n = 0; n < 4; n++) begin
                slot_q[n] <= '0;
            end
        end else if (!i_clear && fire) begin
            slot_q[i_select] <= i_d;
        end
    end

    assign o_q0 = slot_q[0];
    assign o_q1 = slot_q[1];
    assign o_q2 = slot_q[2];
    assign o_q3 = slot_q[3];

endmodule

// File: doc/demultiplexor1_4_stream.md
# demultiplexor1_4_stream

Registered 1-to-4 stream demultiplexer, the inverse of the datapath 4:1 selector. It accepts one 32-bit word per cycle from a single valid/ready source. Each word is steered by a 2-bit select into one of four one-entry output slots, and each slot drains independently through its own valid/ready handshake. It sits between a producer (e.g. a fetch/load unit) and up to four consumers, decoupling them by one register stage.

## Interface

Parameters:
- WIDTH, 32, data width of input and every output slot.

Ports:
- i_clk  in  1  single clock; all state updates on its rising edge.
- i_reset  in  1  reset, synchronous, active-high.
- i_clear  in  1  synchronous flush of all slots (no reset of data registers).
- i_d  in  WIDTH  input data word.
- i_valid  in  1  input word present.
- i_select  in  2  destination slot for i_d (0..3).
- o_ready  out  1  input handshake; transfer when i_valid && o_ready.
- o_q0, o_q1, o_q2, o_q3  out  WIDTH  slot data registers.
- o_valid  out  4  bit n = slot n holds an undelivered word.
- i_ready  in  4  bit n = consumer n takes o_qn this cycle.
- o_accepted  out  16  wrapping count of input transfers since reset.

## Operation

- State: four WIDTH-bit data registers, four full flags (o_valid), one 16-bit counter.
- Slot n drains when o_valid[n] && i_ready[n].
- o_ready = !i_clear && (!o_valid[i_select] || i_ready[i_select]). This is combinational from i_select, o_valid and i_ready; o_ready does not depend on i_valid.
- Input transfer (i_valid && o_ready): data register i_select ← i_d, o_valid[i_select] ← 1, o_accepted ← o_accepted + 1 (mod 2^16).
- Simultaneous drain and fill of the same slot: the new word is written and o_valid stays 1. No bubble, so full throughput to one slot is possible.
- Drain without fill: o_valid[n] ← 0. Data register n holds its last value.
- Non-selected slots are unaffected by input activity. Drains on any slots may occur in the same cycle as a fill of another slot.
- i_valid with o_ready = 0: no state change. The producer must hold i_d/i_select stable until the transfer.
- i_clear = 1: all o_valid ← 0 and o_ready = 0. No transfer is counted. Data registers and o_accepted are unchanged.
- Priority: i_reset > i_clear > transfer/drain.
- i_select ∉ range: impossible (2 bits cover all 4 slots).

## Timing

- Reset values (after the first edge with i_reset = 1): o_valid = 4'b0000, o_q0..o_q3 = 0, o_accepted = 0. o_ready then evaluates to 1 when i_clear = 0.
- Reset mid-operation discards all pending words. No drain is reported for them.
- Latency: a word accepted at edge k appears on o_qn with o_valid[n] = 1 immediately after edge k, so it is drainable in cycle k+1.
- Throughput: 1 word/cycle sustained, to any slot pattern, as long as the targeted consumer keeps i_ready = 1.
- Backpressure: a full slot with i_ready = 0 blocks only words selecting that slot. Words selecting other slots still transfer.
- o_accepted wraps from 16'hFFFF to 16'h0000 on the next transfer.
- No combinational path exists from i_valid to o_ready. o_ready may combinationally depend on i_select and i_ready.

## Test plan

- Reset, then i_valid = 1, i_select = 2, i_d = 32'hDEADBEEF, i_ready = 4'b0000 for 1 cycle -> after the edge, o_valid = 4'b0100, o_q2 = DEADBEEF, o_accepted = 1. Holding the same request: o_ready = 0. Switching i_select = 0: o_ready = 1.
- Slot 1 full, i_ready[1] = 1, input i_select = 1, i_d = 32'h00000005 -> o_ready = 1. After the edge, o_q1 = 5 and o_valid[1] stays 1. Stream 8 words to slot 1 with i_ready[1] held at 1 -> 8 transfers in 8 cycles, consumer sees words in order.
- Round-robin i_select 0,1,2,3 with values 10,11,12,13 and all i_ready = 0 -> o_valid = 4'b1111, o_q0..3 = 10..13. A fifth word to any slot is refused; o_accepted = 4.
- Full slots, assert i_clear for 1 cycle with i_valid = 1 -> o_ready = 0 that cycle. Afterwards o_valid = 0, o_q values unchanged, o_accepted unchanged.
- Preload o_accepted to 16'hFFFF via 65535 transfers, then one more transfer -> o_accepted = 0.
- i_reset asserted while o_valid = 4'b1010 and i_valid = 1 -> after the edge all outputs are at their reset values and the pending input is not counted.
